mul_acc: RTL

Accumulator stage directly downstream of the pipelined 4-bit multiplier `mul`. It issues a batch of N operand-pair acceptances to the multiplier, tracks which products are real through a valid delay line matched to the multiplier latency, and sums the 8-bit products into a saturating ACC_W-bit total. The total is presented with a valid/ack handshake. Together with `mul` it forms the team's multiply-accumulate datapath.

---
 rtl/mul_acc_pkg.sv | 18 +
 rtl/mul_acc_if.sv | 42 ++++
 rtl/mul_acc_valid_delay.sv | 25 ++
 rtl/mul_acc.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// mul_acc shared types and helpers.
// Imported by the accumulator stage and its interface.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int PROD_W = 8;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mul_acc_if.sv
// mul_acc handshake/bus bundle.
// master = upstream/consumer side, slave = mul_acc.
interface mul_acc_if #(
  parameter int ACC_W = 16
);
  import mul_acc_pkg::*;

  logic              start;
  logic              op_valid;
  logic              op_ready;
  logic [PROD_W-1:0] p;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ack;
  logic              ovf;
  logic              busy;

  modport master (
    output start,
    output op_valid,
    output p,
    output sum_ack,
    input  op_ready,
    input  sum,
    input  sum_valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  op_valid,
    input  p,
    input  sum_ack,
    output op_ready,
    output sum,
    output sum_valid,
    output ovf,
    output busy
  );

endinterface

// File: rtl/mul_acc_valid_delay.sv
// LAT-deep 1-bit valid shift register.
// Keeps "product is real" flags aligned with mul.
module valid_delay #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [LAT-1:0] r_sh;

  // shift one stage per cycle; reset drops all in-flight flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else begin
      r_sh <= LAT'({r_sh, i_d});
    end
  end

  assign o_q = r_sh[LAT-1];

endmodule

// File: rtl/mul_acc.sv
// Batch accumulator downstream of the pipelined mul.
// Issues N accepts, sums N products with saturation.
module mul_acc
  import mul_acc_pkg::*;
#(
  parameter int N     = 4,
  parameter int LAT   = 3,
  parameter int ACC_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  mul_acc_if.slave bus
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state;
  logic             r_op_ready;
  logic             r_sum_valid;
  logic             r_busy;
  logic [CW-1:0]    r_iss;
  logic [CW-1:0]    r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_ovf;

  logic             w_run;
  logic             w_drain;
  logic             w_accept;
  logic             w_pop;
  logic             w_add_en;
  logic [ACC_W:0]   w_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_sat;
  logic             w_iss_last;
  logic             w_acc_last;
  logic             w_begin;

  assign w_run    = (r_state == RUN);
  assign w_drain  = (r_state == DRAIN);
  assign w_begin  = (r_state == IDLE) & bus.start;
  assign w_accept = w_run & bus.op_valid;
  assign w_add_en = w_pop & (w_run | w_drain);

  assign w_ext   = {1'b0, r_sum} + (ACC_W + 1)'(bus.p);
  assign w_carry = w_ext[ACC_W];
  assign w_sat   = w_carry ? '1 : w_ext[ACC_W-1:0];

  assign w_iss_last = w_accept & (r_iss == LAST);
  assign w_acc_last = w_add_en & (r_acc == LAST);

  valid_delay #(
    .LAT (LAT)
  ) u_vd (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_accept),
    .o_q   (w_pop)
  );

  // batch counters and saturating sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss <= '0;
      r_acc <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_begin) begin
      r_iss <= '0;
      r_acc <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_iss <= r_iss + CW'(1);
      end
      if (w_add_en) begin
        r_acc <= r_acc + CW'(1);
        r_sum <= w_sat;
        r_ovf <= r_ovf | w_carry;
      end
    end
  end

  // batch FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op_ready  <= 1'b0;
      r_sum_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (bus.start) begin
            r_state    <= RUN;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        (r_state == RUN): begin
          if (w_acc_last) begin
            r_state     <= DONE;
            r_op_ready  <= 1'b0;
            r_sum_valid <= 1'b1;
          end else if (w_iss_last) begin
            r_state    <= DRAIN;
            r_op_ready <= 1'b0;
          end
        end
        (r_state == DRAIN): begin
          if (w_acc_last) begin
            r_state     <= DONE;
            r_sum_valid <= 1'b1;
          end
        end
        (r_state == DONE): begin
          if (bus.sum_ack) begin
            r_state     <= IDLE;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_op_ready  <= 1'b0;
          r_sum_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready  = r_op_ready;
  assign bus.sum_valid = r_sum_valid;
  assign bus.busy      = r_busy;
  assign bus.sum       = r_sum;
  assign bus.ovf       = r_ovf;

endmodule
